// File: rtl/wb_pkg.sv
// Shared encodings for the write-back sequencer: source selects and FSM states.
package wb_pkg;

  localparam logic [1:0] WB_SRC_PC   = 2'b00;
  localparam logic [1:0] WB_SRC_DM   = 2'b01;
  localparam logic [1:0] WB_SRC_ALU  = 2'b10;
  localparam logic [1:0] WB_SRC_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    LOAD_WB   = 2'd2,
    DRAIN     = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Cycle counter for outstanding data-memory loads; flags the cycle in which
// the count would reach DM_TIMEOUT so the sequencer can abort on the next edge.
module wb_timeout_cnt #(
  parameter int DM_TIMEOUT = 15,
  parameter int TO_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Clear has priority so the count restarts on every wait-state entry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry must not depend on clr: clr is derived from the next state,
  // which itself depends on expire.
  assign expire = en && (cnt_q == TO_W'(DM_TIMEOUT - 1));

endmodule

// File: rtl/wb_ctrl.sv
// Write-back sequencer: drives the register-bank write port (mux select,
// write enable, write address) for retiring instructions, holds the pipeline
// while a data-memory load is outstanding, and handles flush.
// Optional load timeout with dm_err pulse: define WB_CTRL_TIMEOUT_EN.
module wb_ctrl
  import wb_pkg::*;
#(
  parameter int RA_W       = 5,
  parameter int DM_TIMEOUT = 15,
  parameter int TO_W       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid,
  input  logic [1:0]      wb_src,
  input  logic [RA_W-1:0] wb_rd,
  output logic            wb_ready,
  input  logic            dm_ack,
  input  logic            flush,
  output logic [1:0]      s_mxrb,
  output logic            rb_we,
  output logic [RA_W-1:0] rb_waddr,
  output logic            stall
`ifdef WB_CTRL_TIMEOUT_EN
  ,
  output logic            dm_err
`endif
);

  // The timeout counter must be able to represent DM_TIMEOUT.
  if ((2 ** TO_W) <= DM_TIMEOUT) begin : g_bad_to_w
    $error("wb_ctrl: TO_W too narrow for DM_TIMEOUT");
  end

  wb_state_e       state_q;
  wb_state_e       state_d;
  logic [1:0]      s_mxrb_q;
  logic [1:0]      s_mxrb_d;
  logic            rb_we_q;
  logic            rb_we_d;
  logic [RA_W-1:0] rb_waddr_q;
  logic [RA_W-1:0] rb_waddr_d;
  logic            accept;
  logic            to_expire;

  assign wb_ready = (state_q == IDLE) && !flush;
  assign accept   = wb_valid && wb_ready;
  assign stall    = (state_q != IDLE);

`ifdef WB_CTRL_TIMEOUT_EN
  logic dm_err_q;
  logic dm_err_d;
  logic to_clr;
  logic to_en;

  // Restart the count whenever a wait state is entered from elsewhere.
  assign to_clr = ((state_q == IDLE) && (state_d == LOAD_WAIT)) ||
                  ((state_q == LOAD_WAIT) && (state_d == DRAIN));
  assign to_en  = (state_q == LOAD_WAIT) || (state_q == DRAIN);

  wb_timeout_cnt #(
    .DM_TIMEOUT (DM_TIMEOUT),
    .TO_W       (TO_W)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (to_clr),
    .en     (to_en),
    .expire (to_expire)
  );

  assign dm_err = dm_err_q;
`else
  // Without the timeout the wait states wait indefinitely for dm_ack.
  assign to_expire = 1'b0;
`endif

  // State and registered outputs; reset aborts any pending write at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_mxrb_q   <= WB_SRC_ALU;
      rb_we_q    <= 1'b0;
      rb_waddr_q <= '0;
`ifdef WB_CTRL_TIMEOUT_EN
      dm_err_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      s_mxrb_q   <= s_mxrb_d;
      rb_we_q    <= rb_we_d;
      rb_waddr_q <= rb_waddr_d;
`ifdef WB_CTRL_TIMEOUT_EN
      dm_err_q   <= dm_err_d;
`endif
    end
  end

  // Next-state logic; flush beats dm_ack in LOAD_WAIT, dm_ack beats timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && (wb_src == WB_SRC_DM)) begin
          state_d = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        if (flush) begin
          state_d = dm_ack ? IDLE : DRAIN;
        end else if (dm_ack) begin
          state_d = LOAD_WB;
        end else if (to_expire) begin
          state_d = IDLE;
        end
      end
      LOAD_WB: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (dm_ack || to_expire) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values of the write port; rb_we is a one-cycle pulse and writes to
  // register 0 are dropped while the select/address still update.
  always_comb begin
    s_mxrb_d   = s_mxrb_q;
    rb_waddr_d = rb_waddr_q;
    rb_we_d    = 1'b0;
`ifdef WB_CTRL_TIMEOUT_EN
    dm_err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept && (wb_src != WB_SRC_NONE)) begin
          s_mxrb_d   = wb_src;
          rb_waddr_d = wb_rd;
          rb_we_d    = (wb_src != WB_SRC_DM) && (wb_rd != '0);
        end
      end
      LOAD_WAIT: begin
        if (!flush && dm_ack) begin
          rb_we_d = (rb_waddr_q != '0);
        end
`ifdef WB_CTRL_TIMEOUT_EN
        else if (!flush && to_expire) begin
          dm_err_d = 1'b1;
        end
`endif
      end
      DRAIN: begin
`ifdef WB_CTRL_TIMEOUT_EN
        if (!dm_ack && to_expire) begin
          dm_err_d = 1'b1;
        end
`endif
      end
      default: begin
      end
    endcase
  end

  assign s_mxrb   = s_mxrb_q;
  assign rb_we    = rb_we_q;
  assign rb_waddr = rb_waddr_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl: a per-cycle vector table plus hand sequences
// for load timeout / indefinite wait and asynchronous reset mid-load.
module tb_wb_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wb_valid;
  logic [1:0] wb_src;
  logic [4:0] wb_rd;
  logic       wb_ready;
  logic       dm_ack;
  logic       flush;
  logic [1:0] s_mxrb;
  logic       rb_we;
  logic [4:0] rb_waddr;
  logic       stall;
`ifdef WB_CTRL_TIMEOUT_EN
  logic       dm_err;
`endif

  int n_checks = 0;
  int n_err    = 0;

  wb_ctrl #(
    .RA_W       (5),
    .DM_TIMEOUT (15),
    .TO_W       (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .wb_src   (wb_src),
    .wb_rd    (wb_rd),
    .wb_ready (wb_ready),
    .dm_ack   (dm_ack),
    .flush    (flush),
    .s_mxrb   (s_mxrb),
    .rb_we    (rb_we),
    .rb_waddr (rb_waddr),
    .stall    (stall)
`ifdef WB_CTRL_TIMEOUT_EN
    ,
    .dm_err   (dm_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] src;
    logic [4:0] rd;
    logic       ack;
    logic       fl;
    logic       we;
    logic [4:0] wa;
    logic [1:0] mx;
    logic       st;
    logic       rdy;
  } vec_t;

  vec_t vecs[39];

  function automatic vec_t mk(input logic v, input logic [1:0] src, input logic [4:0] rd,
                              input logic ack, input logic fl, input logic we,
                              input logic [4:0] wa, input logic [1:0] mx,
                              input logic st, input logic rdy);
    vec_t r;
    r.v = v; r.src = src; r.rd = rd; r.ack = ack; r.fl = fl;
    r.we = we; r.wa = wa; r.mx = mx; r.st = st; r.rdy = rdy;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Apply inputs just after the rising edge, then land on the falling edge.
  task automatic step(input logic v, input logic [1:0] src, input logic [4:0] rd,
                      input logic ack, input logic fl);
    @(posedge clk);
    #1;
    wb_valid = v;
    wb_src   = src;
    wb_rd    = rd;
    dm_ack   = ack;
    flush    = fl;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".rb_we"}, 32'(rb_we), 32'd0);
    chk({tag, ".rb_waddr"}, 32'(rb_waddr), 32'd0);
    chk({tag, ".s_mxrb"}, 32'(s_mxrb), 32'd2);
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    chk({tag, ".wb_ready"}, 32'(wb_ready), 32'd1);
`ifdef WB_CTRL_TIMEOUT_EN
    chk({tag, ".dm_err"}, 32'(dm_err), 32'd0);
`endif
  endtask

  // Pull reset while a load is outstanding, then show a late dm_ack writes nothing.
  task automatic reset_mid_load(input logic [4:0] exp_wa);
    chk("rst.pre_stall", 32'(stall), 32'd1);
    chk("rst.pre_waddr", 32'(rb_waddr), 32'(exp_wa));
    chk("rst.pre_mx", 32'(s_mxrb), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst.async");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1'b0, 2'b00, 5'd0, 1'b1, 1'b0);
    chk("rst.ack_we", 32'(rb_we), 32'd0);
    chk("rst.ack_stall", 32'(stall), 32'd0);
    step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
    chk("rst.after_we", 32'(rb_we), 32'd0);
    chk("rst.after_waddr", 32'(rb_waddr), 32'd0);
    chk("rst.after_ready", 32'(wb_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //             v  src    rd  ack fl | we wa  mx    st rdy
    vecs[0]  = mk(1, 2'b10, 3,  0, 0,   0, 0,  2'b10, 0, 1);
    vecs[1]  = mk(1, 2'b10, 4,  0, 0,   1, 3,  2'b10, 0, 1);
    vecs[2]  = mk(1, 2'b10, 5,  0, 0,   1, 4,  2'b10, 0, 1);
    vecs[3]  = mk(0, 2'b00, 0,  0, 0,   1, 5,  2'b10, 0, 1);
    vecs[4]  = mk(0, 2'b00, 0,  0, 0,   0, 5,  2'b10, 0, 1);
    vecs[5]  = mk(1, 2'b01, 7,  0, 0,   0, 5,  2'b10, 0, 1);
    vecs[6]  = mk(1, 2'b10, 9,  0, 0,   0, 7,  2'b01, 1, 0);
    vecs[7]  = mk(0, 2'b00, 0,  0, 0,   0, 7,  2'b01, 1, 0);
    vecs[8]  = mk(0, 2'b00, 0,  0, 0,   0, 7,  2'b01, 1, 0);
    vecs[9]  = mk(0, 2'b00, 0,  1, 0,   0, 7,  2'b01, 1, 0);
    vecs[10] = mk(0, 2'b00, 0,  0, 0,   1, 7,  2'b01, 1, 0);
    vecs[11] = mk(0, 2'b00, 0,  0, 0,   0, 7,  2'b01, 0, 1);
    vecs[12] = mk(0, 2'b00, 0,  1, 0,   0, 7,  2'b01, 0, 1);
    vecs[13] = mk(1, 2'b10, 0,  0, 0,   0, 7,  2'b01, 0, 1);
    vecs[14] = mk(1, 2'b11, 9,  0, 0,   0, 0,  2'b10, 0, 1);
    vecs[15] = mk(0, 2'b00, 0,  0, 0,   0, 0,  2'b10, 0, 1);
    vecs[16] = mk(1, 2'b00, 12, 0, 0,   0, 0,  2'b10, 0, 1);
    vecs[17] = mk(0, 2'b00, 0,  0, 0,   1, 12, 2'b00, 0, 1);
    vecs[18] = mk(1, 2'b10, 1,  0, 1,   0, 12, 2'b00, 0, 0);
    vecs[19] = mk(0, 2'b00, 0,  0, 0,   0, 12, 2'b00, 0, 1);
    vecs[20] = mk(1, 2'b01, 6,  0, 0,   0, 12, 2'b00, 0, 1);
    vecs[21] = mk(0, 2'b00, 0,  0, 0,   0, 6,  2'b01, 1, 0);
    vecs[22] = mk(0, 2'b00, 0,  0, 1,   0, 6,  2'b01, 1, 0);
    vecs[23] = mk(0, 2'b00, 0,  0, 0,   0, 6,  2'b01, 1, 0);
    vecs[24] = mk(0, 2'b00, 0,  0, 0,   0, 6,  2'b01, 1, 0);
    vecs[25] = mk(0, 2'b00, 0,  1, 0,   0, 6,  2'b01, 1, 0);
    vecs[26] = mk(0, 2'b00, 0,  0, 0,   0, 6,  2'b01, 0, 1);
    vecs[27] = mk(1, 2'b01, 8,  0, 0,   0, 6,  2'b01, 0, 1);
    vecs[28] = mk(0, 2'b00, 0,  1, 1,   0, 8,  2'b01, 1, 0);
    vecs[29] = mk(0, 2'b00, 0,  0, 0,   0, 8,  2'b01, 0, 1);
    vecs[30] = mk(0, 2'b00, 0,  0, 0,   0, 8,  2'b01, 0, 1);
    vecs[31] = mk(1, 2'b01, 10, 0, 0,   0, 8,  2'b01, 0, 1);
    vecs[32] = mk(0, 2'b00, 0,  1, 0,   0, 10, 2'b01, 1, 0);
    vecs[33] = mk(0, 2'b00, 0,  0, 1,   1, 10, 2'b01, 1, 0);
    vecs[34] = mk(0, 2'b00, 0,  0, 0,   0, 10, 2'b01, 0, 1);
    vecs[35] = mk(1, 2'b01, 0,  0, 0,   0, 10, 2'b01, 0, 1);
    vecs[36] = mk(0, 2'b00, 0,  1, 0,   0, 0,  2'b01, 1, 0);
    vecs[37] = mk(0, 2'b00, 0,  0, 0,   0, 0,  2'b01, 1, 0);
    vecs[38] = mk(0, 2'b00, 0,  0, 0,   0, 0,  2'b01, 0, 1);

    rst_n    = 1'b0;
    wb_valid = 1'b0;
    wb_src   = 2'b00;
    wb_rd    = 5'd0;
    dm_ack   = 1'b0;
    flush    = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_reset");

    for (int i = 0; i < 39; i++) begin
      step(vecs[i].v, vecs[i].src, vecs[i].rd, vecs[i].ack, vecs[i].fl);
      chk($sformatf("v%0d.rb_we", i), 32'(rb_we), 32'(vecs[i].we));
      chk($sformatf("v%0d.rb_waddr", i), 32'(rb_waddr), 32'(vecs[i].wa));
      chk($sformatf("v%0d.s_mxrb", i), 32'(s_mxrb), 32'(vecs[i].mx));
      chk($sformatf("v%0d.stall", i), 32'(stall), 32'(vecs[i].st));
      chk($sformatf("v%0d.wb_ready", i), 32'(wb_ready), 32'(vecs[i].rdy));
`ifdef WB_CTRL_TIMEOUT_EN
      chk($sformatf("v%0d.dm_err", i), 32'(dm_err), 32'd0);
`endif
    end

    // Load with no dm_ack: rd=11 accepted, LOAD_WAIT entered on the next cycle.
    step(1'b1, 2'b01, 5'd11, 1'b0, 1'b0);
`ifdef WB_CTRL_TIMEOUT_EN
    for (int k = 1; k <= 17; k++) begin
      step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
      if (k == 15) begin
        chk("to.k15_err", 32'(dm_err), 32'd0);
        chk("to.k15_stall", 32'(stall), 32'd1);
      end else if (k == 16) begin
        chk("to.k16_err", 32'(dm_err), 32'd1);
        chk("to.k16_stall", 32'(stall), 32'd0);
        chk("to.k16_we", 32'(rb_we), 32'd0);
        chk("to.k16_ready", 32'(wb_ready), 32'd1);
      end else if (k == 17) begin
        chk("to.k17_err", 32'(dm_err), 32'd0);
        chk("to.k17_we", 32'(rb_we), 32'd0);
      end else begin
        chk($sformatf("to.k%0d_we", k), 32'(rb_we), 32'd0);
      end
    end
    step(1'b1, 2'b01, 5'd13, 1'b0, 1'b0);
    step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
    step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
    reset_mid_load(5'd13);
`else
    for (int k = 1; k <= 100; k++) begin
      step(1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
      if (rb_we !== 1'b0) chk($sformatf("wait.k%0d_we", k), 32'(rb_we), 32'd0);
    end
    chk("wait.stall100", 32'(stall), 32'd1);
    chk("wait.ready100", 32'(wb_ready), 32'd0);
    reset_mid_load(5'd11);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
